// File: rtl/fifo_arbiter_pkg.sv
// fifo_arbiter_pkg: shared types and constants for fifo_request_arbiter.
// Holds the output-register FSM encoding, the grant counter width and a
// saturating increment helper used by the optional grant counters
// (FIFO_ARB_GRANT_COUNTER_EN).
package fifo_arbiter_pkg;

    // Output register occupancy: EMPTY = no request held, FULL = held.
    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    localparam int GRANT_COUNTER_WIDTH = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [GRANT_COUNTER_WIDTH-1:0] sat_inc(
        input logic [GRANT_COUNTER_WIDTH-1:0] v
    );
        if (v == {GRANT_COUNTER_WIDTH{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_request_arbiter_picker.sv
// round_robin_picker: combinational round-robin selector.
// Ports: valid_i (request vector), last_grant_i (previous winner),
//        grant_onehot_o, grant_idx_o (winner), any_valid_o.
// The search starts at last_grant_i+1 and wraps modulo NUM_REQUESTERS.
module round_robin_picker #(
    parameter int NUM_REQUESTERS      = 4,
    parameter int NUM_REQUESTERS_LOG2 = 2
) (
    input  logic [NUM_REQUESTERS-1:0]      valid_i,
    input  logic [NUM_REQUESTERS_LOG2-1:0] last_grant_i,
    output logic [NUM_REQUESTERS-1:0]      grant_onehot_o,
    output logic [NUM_REQUESTERS_LOG2-1:0] grant_idx_o,
    output logic                           any_valid_o
);

    int                           pos;
    logic [NUM_REQUESTERS_LOG2-1:0] pidx;
    logic                         found;

    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        found          = 1'b0;
        pos            = 0;
        pidx           = '0;
        // Offsets 1..N visit every port once, the last one being the
        // previous winner itself, so a lone requester always wins.
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            pos = int'(last_grant_i) + i;
            if (pos >= NUM_REQUESTERS) begin
                pos = pos - NUM_REQUESTERS;
            end
            pidx = NUM_REQUESTERS_LOG2'(pos);
            if (!found && valid_i[pidx]) begin
                found                = 1'b1;
                grant_onehot_o[pidx] = 1'b1;
                grant_idx_o          = pidx;
            end
        end
        any_valid_o = |valid_i;
    end

endmodule

// File: rtl/fifo_request_arbiter.sv
// fifo_request_arbiter: round-robin merge of NUM_REQUESTERS valid/ack
// producers into one registered request toward a fifo_queue write port.
// Upstream: request_packed_in / request_valid_packed_in / issue_ack_packed_out.
// Downstream: request_out / request_source_out / request_valid_out / issue_ack_in.
// grant_count_packed_out: per-port saturating grant counters when
// FIFO_ARB_GRANT_COUNTER_EN is defined, otherwise constant zero.
module fifo_request_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS             = 4,
    parameter int NUM_REQUESTERS_LOG2        = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32
) (
    input  logic                                              clk_in,
    input  logic                                              reset_in,
    input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
    input  logic [NUM_REQUESTERS-1:0]                         request_valid_packed_in,
    output logic [NUM_REQUESTERS-1:0]                         issue_ack_packed_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             request_out,
    output logic [NUM_REQUESTERS_LOG2-1:0]                    request_source_out,
    output logic                                              request_valid_out,
    input  logic                                              issue_ack_in,
    output logic [NUM_REQUESTERS*GRANT_COUNTER_WIDTH-1:0]     grant_count_packed_out
);

    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    arb_state_e                     state_q, state_d;
    logic [NUM_REQUESTERS_LOG2-1:0] last_q, last_d;
    logic [W-1:0]                   data_q, data_d;
    logic [NUM_REQUESTERS_LOG2-1:0] src_q, src_d;

    logic [NUM_REQUESTERS-1:0]      pick_onehot;
    logic [NUM_REQUESTERS_LOG2-1:0] pick_idx;
    logic                           any_valid;
    logic                           slot_free;
    logic                           grant_fire;
    logic [W-1:0]                   pick_data;

    round_robin_picker #(
        .NUM_REQUESTERS      (NUM_REQUESTERS),
        .NUM_REQUESTERS_LOG2 (NUM_REQUESTERS_LOG2)
    ) u_picker (
        .valid_i        (request_valid_packed_in),
        .last_grant_i   (last_q),
        .grant_onehot_o (pick_onehot),
        .grant_idx_o    (pick_idx),
        .any_valid_o    (any_valid)
    );

    // The slot frees either because it is empty or because the held
    // request leaves this very edge. Reset suppresses the grant so no
    // requester believes it transferred into a register being cleared.
    assign slot_free  = (state_q == ARB_EMPTY) || issue_ack_in;
    assign grant_fire = slot_free && any_valid && !reset_in;

    // One-hot mux of the winning payload slice.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (pick_onehot[k]) begin
                pick_data = pick_data | request_packed_in[k*W +: W];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ARB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: begin
                if (any_valid) begin
                    state_d = ARB_FULL;
                end
            end
            ARB_FULL: begin
                if (issue_ack_in && !any_valid) begin
                    state_d = ARB_EMPTY;
                end
            end
            default: state_d = ARB_EMPTY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        issue_ack_packed_out = '0;
        if (grant_fire) begin
            issue_ack_packed_out = pick_onehot;
        end
        request_valid_out = (state_q == ARB_FULL);
    end

    // Output register and round-robin pointer: both move only on a grant,
    // so the held request stays stable while stalled.
    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        last_d = last_q;
        if (grant_fire) begin
            data_d = pick_data;
            src_d  = pick_idx;
            last_d = pick_idx;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            data_q <= '0;
            src_q  <= '0;
            last_q <= NUM_REQUESTERS_LOG2'(NUM_REQUESTERS - 1);
        end else begin
            data_q <= data_d;
            src_q  <= src_d;
            last_q <= last_d;
        end
    end

    assign request_out        = data_q;
    assign request_source_out = src_q;

`ifdef FIFO_ARB_GRANT_COUNTER_EN
    logic [GRANT_COUNTER_WIDTH-1:0] cnt_q [NUM_REQUESTERS];
    logic [GRANT_COUNTER_WIDTH-1:0] cnt_d [NUM_REQUESTERS];

    always_comb begin
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (issue_ack_packed_out[k]) begin
                cnt_d[k] = sat_inc(cnt_q[k]);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (reset_in) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        grant_count_packed_out = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            grant_count_packed_out[k*GRANT_COUNTER_WIDTH +: GRANT_COUNTER_WIDTH] = cnt_q[k];
        end
    end
`else
    assign grant_count_packed_out = '0;
`endif

endmodule

// File: tb/tb_fifo_request_arbiter.sv
// tb_fifo_request_arbiter: randomized and directed stimulus for
// fifo_request_arbiter, compared cycle by cycle against a behavioural model.
module tb_fifo_request_arbiter;

    localparam int N   = 4;
    localparam int LG  = 2;
    localparam int W   = 32;
    localparam int CW  = 32;
    localparam int CHW = N * CW;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [N*W-1:0] request_packed_in;
    logic [N-1:0]   request_valid_packed_in;
    logic [N-1:0]   issue_ack_packed_out;
    logic [W-1:0]   request_out;
    logic [LG-1:0]  request_source_out;
    logic           request_valid_out;
    logic           issue_ack_in;
    logic [N*CW-1:0] grant_count_packed_out;

    always #5 clk_in = ~clk_in;

    fifo_request_arbiter #(
        .NUM_REQUESTERS             (N),
        .NUM_REQUESTERS_LOG2        (LG),
        .SINGLE_ENTRY_WIDTH_IN_BITS (W)
    ) dut (
        .clk_in                  (clk_in),
        .reset_in                (reset_in),
        .request_packed_in       (request_packed_in),
        .request_valid_packed_in (request_valid_packed_in),
        .issue_ack_packed_out    (issue_ack_packed_out),
        .request_out             (request_out),
        .request_source_out      (request_source_out),
        .request_valid_out       (request_valid_out),
        .issue_ack_in            (issue_ack_in),
        .grant_count_packed_out  (grant_count_packed_out)
    );

    int checks;
    int errors;

    task automatic check(input string tag, input logic [CHW-1:0] got,
                         input logic [CHW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: occupancy, held payload/source, last winner, counts.
    bit          m_full;
    bit          m_known;
    logic [W-1:0] m_data;
    int          m_src;
    int          m_last;
    longint      m_cnt [N];

    // Producers: each holds valid and payload until acknowledged.
    bit          rv [N];
    logic [W-1:0] rd [N];
    int          gq [$];

    logic [N-1:0] p_mask;
    int          p_raise;
    int          p_ack;
    int          p_rst;

    task automatic model_reset();
        m_full  = 1'b0;
        m_known = 1'b1;
        m_data  = '0;
        m_src   = 0;
        m_last  = N - 1;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic prefill(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[k] && !rv[k]) begin
                rv[k] = 1'b1;
                rd[k] = $urandom;
            end
        end
    endtask

    task automatic cycle();
        int win;
        bit free;
        logic [N-1:0] exp_ack;
        logic [CHW-1:0] exp_cnt;
        for (int k = 0; k < N; k++) begin
            request_valid_packed_in[k] = rv[k];
            request_packed_in[k*W +: W] = rd[k];
        end
        issue_ack_in = ($urandom_range(99) < p_ack);
        reset_in     = ($urandom_range(99) < p_rst);
        @(negedge clk_in);
        win  = -1;
        free = !m_full || issue_ack_in;
        if (free && !reset_in) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (rv[k]) begin
                    win = k;
                    break;
                end
            end
        end
        exp_ack = '0;
        if (win >= 0) exp_ack[win] = 1'b1;
        check("ack", CHW'(issue_ack_packed_out), CHW'(exp_ack));
        check("valid_out", CHW'(request_valid_out), CHW'(m_full));
        if (m_full || m_known) begin
            check("request_out", CHW'(request_out), CHW'(m_data));
            check("source_out", CHW'(request_source_out), CHW'(m_src));
        end
        exp_cnt = '0;
`ifdef FIFO_ARB_GRANT_COUNTER_EN
        for (int k = 0; k < N; k++) exp_cnt[k*CW +: CW] = m_cnt[k][CW-1:0];
`endif
        check("grant_count", grant_count_packed_out, exp_cnt);
        @(posedge clk_in);
        #1;
        if (reset_in) begin
            model_reset();
        end else if (win >= 0) begin
            m_full = 1'b1;
            m_data = rd[win];
            m_src  = win;
            m_last = win;
            if (m_cnt[win] < 64'hFFFF_FFFF) m_cnt[win]++;
            gq.push_back(win);
            rv[win] = 1'b0;
        end else if (m_full && issue_ack_in) begin
            m_full  = 1'b0;
            m_known = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (!rv[k] && p_mask[k] && ($urandom_range(99) < p_raise)) begin
                rv[k] = 1'b1;
                rd[k] = $urandom;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int n2;
        logic [CW-1:0] exp9;
        checks = 0;
        errors = 0;
        for (int k = 0; k < N; k++) begin
            rv[k] = 1'b0;
            rd[k] = '0;
        end
        reset_in = 1'b1;
        issue_ack_in = 1'b0;
        request_packed_in = '0;
        request_valid_packed_in = '0;
        p_mask = '0; p_raise = 0; p_ack = 0; p_rst = 100;
        @(posedge clk_in);
        #1;
        model_reset();

        // Held in reset, nothing requesting.
        run(5);
        p_rst = 0;

        // All ports continuously valid, downstream always ready.
        prefill(4'hF);
        p_mask = 4'hF; p_raise = 100; p_ack = 100;
        gq.delete();
        run(16);
        check("rr_grants", CHW'(gq.size()), CHW'(16));
        for (int i = 0; i < gq.size(); i++) begin
            check("rr_order", CHW'(gq[i]), CHW'(i % N));
        end

        // Drain.
        p_mask = '0; p_raise = 0;
        run(6);

        // Lone persistent requester on port 2.
        prefill(4'b0100);
        p_mask = 4'b0100; p_raise = 100;
        gq.delete();
        run(10);
        n2 = 0;
        foreach (gq[i]) if (gq[i] == 2) n2++;
        check("p2_grants", CHW'(gq.size()), CHW'(10));
        check("p2_only", CHW'(n2), CHW'(10));
        p_mask = '0; p_raise = 0;
        run(4);

        // Ports 0 and 1 against a stalled downstream.
        prefill(4'b0011);
        p_ack = 0;
        gq.delete();
        run(8);
        check("stall_grants", CHW'(gq.size()), CHW'(1));
        if (gq.size() > 0) check("stall_first", CHW'(gq[0]), CHW'(0));
        p_ack = 100;
        gq.delete();
        run(1);
        check("resume_grants", CHW'(gq.size()), CHW'(1));
        if (gq.size() > 0) check("resume_port", CHW'(gq[0]), CHW'(1));
        run(3);

        // Reset while FULL (winner port 1) with port 3 pending.
        p_ack = 0;
        prefill(4'b0010);
        run(1);
        prefill(4'b1000);
        run(1);
        p_rst = 100;
        run(1);
        p_rst = 0;
        prefill(4'b0001);
        p_ack = 100;
        gq.delete();
        run(1);
        if (gq.size() > 0) check("post_reset_port", CHW'(gq[0]), CHW'(0));
        else check("post_reset_grant", CHW'(0), CHW'(1));
        run(3);

        // Random traffic, backpressure and occasional reset.
        p_mask = 4'hF; p_raise = 40; p_ack = 60; p_rst = 2;
        run(400);

        // 36 back-to-back round-robin grants after a fresh reset.
        p_rst = 100;
        run(1);
        p_rst = 0;
        prefill(4'hF);
        p_raise = 100; p_ack = 100;
        run(36);
`ifdef FIFO_ARB_GRANT_COUNTER_EN
        exp9 = 32'd9;
`else
        exp9 = 32'd0;
`endif
        for (int k = 0; k < N; k++) begin
            check("cnt36", CHW'(grant_count_packed_out[k*CW +: CW]), CHW'(exp9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
